// File: rtl/des_encipher_round_ctrl.sv
// Encipher-side round sequencer for the DES core: IDLE -> LOAD -> ROUND x ROUNDS -> DONE.
// Optional build macro DES_ENC_ABORT_EN adds an enc_abort input that cancels a block in flight.
module des_encipher_round_ctrl #(
    parameter int unsigned ROUNDS = 16,
    parameter int unsigned CNT_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef DES_ENC_ABORT_EN
    input  logic             enc_abort,
`endif
    input  logic             des_encipher_en,
    input  logic             des_decipher_en,
    input  logic             key_process,
    input  logic             decipher_process,
    input  logic             dout_ready,
    output logic             encipher_process,
    output logic             load_block,
    output logic             round_en,
    output logic [CNT_W-1:0] round_cnt,
    output logic             k16_complete,
    output logic             dout_valid,
    output logic             enc_ready,
    output logic             start_reject
);

    typedef enum logic [1:0] {StIdle, StLoad, StRound, StDone} state_e;

    localparam logic [CNT_W-1:0] LastRound = CNT_W'(ROUNDS - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_d;
    logic             abort;
    logic             accept;
    logic             k16_q;

`ifdef DES_ENC_ABORT_EN
    assign abort = enc_abort;
`else
    assign abort = 1'b0;
`endif

    assign accept = des_encipher_en & ~des_decipher_en & ~key_process & ~decipher_process
                  & ((state_q == StIdle) | ((state_q == StDone) & dout_ready));

    always_comb begin
        state_d = state_q;
        cnt_d   = round_cnt;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StLoad;
            end
            StLoad: begin
                cnt_d   = '0;
                state_d = abort ? StIdle : StRound;
            end
            StRound: begin
                // Abort wins over the ROUND->DONE exit.
                if (abort) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (round_cnt == LastRound) begin
                    state_d = StDone;
                    cnt_d   = '0;
                end else begin
                    cnt_d = round_cnt + 1'b1;
                end
            end
            StDone: begin
                if (dout_ready) state_d = accept ? StLoad : StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they track state_q exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            round_cnt        <= '0;
            encipher_process <= 1'b0;
            load_block       <= 1'b0;
            round_en         <= 1'b0;
            k16_q            <= 1'b0;
            dout_valid       <= 1'b0;
        end else begin
            state_q          <= state_d;
            round_cnt        <= cnt_d;
            encipher_process <= (state_d != StIdle);
            load_block       <= (state_d == StLoad);
            round_en         <= (state_d == StRound);
            k16_q            <= (state_d == StRound) && (cnt_d == LastRound);
            dout_valid       <= (state_d == StDone);
        end
    end

    // An abort on the last round suppresses the completion pulse as well.
    assign k16_complete = k16_q & ~abort;
    assign enc_ready    = (state_q == StIdle) & ~key_process & ~decipher_process;
    assign start_reject = des_encipher_en & ~accept;

endmodule
